exe: RTL and testbench

- Execute stage of the single-cycle (SEQ) Y86-64 processor.
- Computes the 64-bit ALU result `val_e` from the decoded `icode`/`ifun` and the operands `val_a`, `val_b`, `val_c`.
- Holds the architectural condition codes (ZF, SF, OF) and evaluates the branch/cmov condition `cnd`.
- Sits between decode (operand supply) and memory/write-back (consumers of `val_e`/`cnd`).

---
 rtl/y86_pkg.sv | 50 +++++
 rtl/exe_alu.sv | 54 +++++
 rtl/exe.sv | 92 +++++++++
 tb/tb_exe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the execute stage.
//   - icode constants for every instruction class the stage decodes
//   - ALU function codes carried in ifun for OPq
//   - condition function codes carried in ifun for cmovXX / jXX
//   - condition-code layout and reset value
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    // ALU function codes (ifun of OPq)
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    // Condition function codes (ifun of cmovXX / jXX)
    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    // Condition-code bit positions inside the 3-bit {ZF, SF, OF} vector
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/exe_alu.sv
// Combinational 64-bit ALU used by OPq.
// Ports:
//   alu_a, alu_b  : operands (result is formed as B op A)
//   alu_fn        : ALU function code (add/sub/and/xor)
//   alu_res       : result, 0 for an undefined function code
//   alu_flags     : {ZF, SF, OF} the result would produce
//   alu_fn_ok     : high when alu_fn names a defined operation
module exe_alu
    import y86_pkg::*;
(
    input  logic [63:0] alu_a,
    input  logic [63:0] alu_b,
    input  logic [3:0]  alu_fn,
    output logic [63:0] alu_res,
    output cc_t         alu_flags,
    output logic        alu_fn_ok
);

    logic [63:0] sum;
    logic [63:0] diff;
    logic        of_add;
    logic        of_sub;

    assign sum  = alu_b + alu_a;
    assign diff = alu_b - alu_a;

    // Signed overflow: add overflows when like-signed operands give a
    // differently-signed sum; sub overflows when unlike-signed operands give
    // a result whose sign differs from the minuend B.
    assign of_add = (alu_a[63] == alu_b[63]) && (sum[63] != alu_a[63]);
    assign of_sub = (alu_a[63] != alu_b[63]) && (diff[63] != alu_b[63]);

    always_comb begin
        alu_res   = 64'd0;
        alu_fn_ok = 1'b1;
        alu_flags = '0;
        unique case (alu_fn)
            ALU_ADD: begin
                alu_res      = sum;
                alu_flags.of = of_add;
            end
            ALU_SUB: begin
                alu_res      = diff;
                alu_flags.of = of_sub;
            end
            ALU_AND: alu_res = alu_b & alu_a;
            ALU_XOR: alu_res = alu_b ^ alu_a;
            default: alu_fn_ok = 1'b0;
        endcase
        alu_flags.zf = (alu_res == 64'd0);
        alu_flags.sf = alu_res[63];
    end

endmodule

// File: rtl/exe.sv
// Execute stage of the single-cycle Y86-64 processor.
// Ports:
//   clock, reset         : clock and synchronous active-high reset
//   in_code, in_fun      : decoded icode / ifun
//   val_a, val_b, val_c  : operands from decode (rA, rB/%rsp, immediate)
//   val_e                : ALU result (combinational)
//   cnd                  : cmovXX/jXX condition against the registered CC
//   cc                   : registered {ZF, SF, OF}
module exe
    import y86_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  in_code,
    input  logic [3:0]  in_fun,
    input  logic [63:0] val_a,
    input  logic [63:0] val_b,
    input  logic [63:0] val_c,
    output logic [63:0] val_e,
    output logic        cnd,
    output logic [2:0]  cc
);

    cc_t         cc_q;
    cc_t         cc_d;
    logic [63:0] alu_res;
    cc_t         alu_flags;
    logic        alu_fn_ok;
    logic        lt;

    exe_alu u_alu (
        .alu_a     (val_a),
        .alu_b     (val_b),
        .alu_fn    (in_fun),
        .alu_res   (alu_res),
        .alu_flags (alu_flags),
        .alu_fn_ok (alu_fn_ok)
    );

    // Result selection by instruction class
    always_comb begin
        val_e = 64'd0;
        unique case (in_code)
            I_CMOV:          val_e = val_a;
            I_IRMOV:         val_e = val_c;
            I_RMMOV,
            I_MRMOV:         val_e = val_b + val_c;
            I_OPQ:           val_e = alu_res;
            I_CALL, I_PUSH:  val_e = val_b - 64'd8;
            I_RET,  I_POP:   val_e = val_b + 64'd8;
            default:         val_e = 64'd0;
        endcase
    end

    // Only a valid OPq writes the flags; everything else holds them.
    always_comb begin
        cc_d = cc_q;
        if ((in_code == I_OPQ) && alu_fn_ok) begin
            cc_d = alu_flags;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cc_q <= CC_RESET;
        end else begin
            cc_q <= cc_d;
        end
    end

    // Condition uses the flags as they stood before this instruction.
    assign lt = cc_q.sf ^ cc_q.of;

    always_comb begin
        cnd = 1'b0;
        if ((in_code == I_CMOV) || (in_code == I_JXX)) begin
            unique case (in_fun)
                C_ALWAYS: cnd = 1'b1;
                C_LE:     cnd = lt | cc_q.zf;
                C_L:      cnd = lt;
                C_E:      cnd = cc_q.zf;
                C_NE:     cnd = ~cc_q.zf;
                C_GE:     cnd = ~lt;
                C_G:      cnd = ~lt & ~cc_q.zf;
                default:  cnd = 1'b0;
            endcase
        end
    end

    assign cc = cc_q;

endmodule

// File: tb/tb_exe.sv
// Self-checking bench for the Y86-64 execute stage.
module tb_exe;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  in_code;
    logic [3:0]  in_fun;
    logic [63:0] val_a;
    logic [63:0] val_b;
    logic [63:0] val_c;
    logic [63:0] val_e;
    logic        cnd;
    logic [2:0]  cc;

    int total = 0;
    int bad   = 0;

    logic [2:0] m_cc;
    bit         started = 1'b0;

    exe dut (
        .clock   (clock),
        .reset   (reset),
        .in_code (in_code),
        .in_fun  (in_fun),
        .val_a   (val_a),
        .val_b   (val_b),
        .val_c   (val_c),
        .val_e   (val_e),
        .cnd     (cnd),
        .cc      (cc)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    function automatic logic [63:0] m_vale(input logic [3:0] code, input logic [3:0] fun,
                                           input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] c);
        case (code)
            4'd2:        return a;
            4'd3:        return c;
            4'd4, 4'd5:  return b + c;
            4'd6: begin
                case (fun)
                    4'd0:    return b + a;
                    4'd1:    return b - a;
                    4'd2:    return b & a;
                    4'd3:    return b ^ a;
                    default: return 64'd0;
                endcase
            end
            4'd8, 4'd10: return b - 64'd8;
            4'd9, 4'd11: return b + 64'd8;
            default:     return 64'd0;
        endcase
    endfunction

    // Flags via a 65-bit sign-extended exact result: overflow whenever the
    // exact result does not fit in 64 signed bits.
    function automatic logic [2:0] m_flags(input logic [3:0] fun,
                                           input logic [63:0] a, input logic [63:0] b);
        logic [64:0] ex;
        logic [63:0] r;
        logic        of;
        ex = 65'd0;
        r  = m_vale(4'd6, fun, a, b, 64'd0);
        of = 1'b0;
        if (fun == 4'd0) begin
            ex = {b[63], b} + {a[63], a};
            of = ex[64] != ex[63];
        end else if (fun == 4'd1) begin
            ex = {b[63], b} - {a[63], a};
            of = ex[64] != ex[63];
        end
        return {r == 64'd0, r[63], of};
    endfunction

    function automatic logic m_cnd(input logic [3:0] code, input logic [3:0] fun,
                                   input logic [2:0] f);
        logic zf, less;
        zf   = f[2];
        less = f[1] != f[0];
        if (code != 4'd2 && code != 4'd7) return 1'b0;
        case (fun)
            4'd0:    return 1'b1;
            4'd1:    return less || zf;
            4'd2:    return less;
            4'd3:    return zf;
            4'd4:    return !zf;
            4'd5:    return !less;
            4'd6:    return !less && !zf;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clock) begin
        if (reset) m_cc <= 3'b100;
        else if (in_code == 4'd6 && in_fun < 4'd4) m_cc <= m_flags(in_fun, val_a, val_b);
        started <= 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One compare process against the model, every cycle.
    always @(negedge clock) begin
        if (started) begin
            check("model_val_e", val_e, m_vale(in_code, in_fun, val_a, val_b, val_c));
            check("model_cnd", {63'd0, cnd}, {63'd0, m_cnd(in_code, in_fun, m_cc)});
            check("model_cc", {61'd0, cc}, {61'd0, m_cc});
        end
    end

    // Apply one instruction just after a rising edge, return after the next
    // falling edge so combinational outputs are settled.
    task automatic step(input logic [3:0] code, input logic [3:0] fun, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] c, input logic rst);
        @(posedge clock);
        #1;
        reset = rst; in_code = code; in_fun = fun; val_a = a; val_b = b; val_c = c;
        @(negedge clock);
        #1;
        $display("step: rst=%0b code=%0d fun=%0d a=%h b=%h c=%h -> val_e=%h cnd=%0b cc=%b",
                 rst, code, fun, a, b, c, val_e, cnd, cc);
    endtask

    typedef struct {
        logic [3:0]  code;
        logic [3:0]  fun;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
    } vec_t;

    vec_t vecs[14];

    initial begin
        reset = 1'b1; in_code = 4'd0; in_fun = 4'd0;
        val_a = 64'd0; val_b = 64'd0; val_c = 64'd0;
        step(4'd0, 4'd0, 64'd0, 64'd0, 64'd0, 1'b1);
        step(4'd0, 4'd0, 64'd0, 64'd0, 64'd0, 1'b1);
        check("reset_cc", {61'd0, cc}, 64'd4);

        step(4'd5, 4'd4, 64'd10, 64'd50, 64'd20, 1'b0);
        check("mrmov_val_e", val_e, 64'd70);
        check("mrmov_cnd", {63'd0, cnd}, 64'd0);
        step(4'd5, 4'd4, 64'd10, 64'd50, 64'd20, 1'b0);
        check("mrmov_cc_hold", {61'd0, cc}, 64'd4);

        step(4'd6, 4'd1, 64'd10, 64'd50, 64'd0, 1'b0);
        check("sub_val_e", val_e, 64'd40);
        step(4'd2, 4'd0, 64'd10, 64'd0, 64'd0, 1'b0);
        check("sub_cc", {61'd0, cc}, 64'd0);
        check("rrmov_val_e", val_e, 64'd10);
        check("rrmov_cnd", {63'd0, cnd}, 64'd1);
        step(4'd2, 4'd4, 64'd10, 64'd0, 64'd0, 1'b0);
        check("cmovne_cnd", {63'd0, cnd}, 64'd1);
        step(4'd2, 4'd3, 64'd10, 64'd0, 64'd0, 1'b0);
        check("cmove_cnd", {63'd0, cnd}, 64'd0);

        step(4'd6, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        check("add_ovf_val_e", val_e, 64'hFFFF_FFFF_FFFF_FFFE);
        step(4'd7, 4'd2, 64'd0, 64'd0, 64'd0, 1'b0);
        check("add_ovf_cc", {61'd0, cc}, 64'd3);
        check("jl_cnd", {63'd0, cnd}, 64'd0);
        step(4'd7, 4'd1, 64'd0, 64'd0, 64'd0, 1'b0);
        check("jle_cnd", {63'd0, cnd}, 64'd0);

        step(4'd6, 4'd3, 64'd5, 64'd5, 64'd0, 1'b0);
        check("xor_val_e", val_e, 64'd0);
        step(4'd7, 4'd3, 64'd0, 64'd0, 64'd0, 1'b0);
        check("xor_cc", {61'd0, cc}, 64'd4);
        check("je_cnd", {63'd0, cnd}, 64'd1);

        step(4'd8, 4'd0, 64'd0, 64'd100, 64'd0, 1'b0);
        check("call_val_e", val_e, 64'd92);
        step(4'd11, 4'd0, 64'd0, 64'd100, 64'd0, 1'b0);
        check("pop_val_e", val_e, 64'd108);

        // Move CC away from its reset value, then reset during an OPq sub.
        step(4'd6, 4'd0, 64'd1, 64'd1, 64'd0, 1'b0);
        step(4'd6, 4'd1, 64'd2, 64'd1, 64'd0, 1'b1);
        check("pre_reset_cc", {61'd0, cc}, 64'd0);
        check("reset_sub_val_e", val_e, 64'hFFFF_FFFF_FFFF_FFFF);
        step(4'd1, 4'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        check("reset_sub_cc", {61'd0, cc}, 64'd4);

        // First OPq after reset updates CC: 1 - 2 = -1 -> {0,1,0}.
        step(4'd6, 4'd1, 64'd2, 64'd1, 64'd0, 1'b0);
        step(4'd6, 4'd7, 64'd3, 64'd3, 64'd0, 1'b0);
        check("post_reset_cc", {61'd0, cc}, 64'd2);
        check("opq_bad_fun_val_e", val_e, 64'd0);
        step(4'd7, 4'd5, 64'd0, 64'd0, 64'd0, 1'b0);
        check("opq_bad_fun_cc_hold", {61'd0, cc}, 64'd2);
        check("jge_cnd", {63'd0, cnd}, 64'd0);

        // Further directed vectors, checked by the model.
        vecs[0]  = '{4'd6, 4'd1, 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, 64'd0};
        vecs[1]  = '{4'd7, 4'd6, 64'd0, 64'd0, 64'd0};
        vecs[2]  = '{4'd2, 4'd5, 64'h1234, 64'd0, 64'd0};
        vecs[3]  = '{4'd6, 4'd2, 64'hF0F0_F0F0_0000_FFFF, 64'hFF00_FF00_FF00_FF00, 64'd0};
        vecs[4]  = '{4'd2, 4'd1, 64'd7, 64'd0, 64'd0};
        vecs[5]  = '{4'd6, 4'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0};
        vecs[6]  = '{4'd7, 4'd4, 64'd0, 64'd0, 64'd0};
        vecs[7]  = '{4'd3, 4'd0, 64'd1, 64'd2, 64'hDEAD_BEEF};
        vecs[8]  = '{4'd10, 4'd0, 64'd0, 64'd4, 64'd0};
        vecs[9]  = '{4'd9, 4'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0};
        vecs[10] = '{4'd12, 4'd0, 64'd9, 64'd9, 64'd9};
        vecs[11] = '{4'd7, 4'd9, 64'd0, 64'd0, 64'd0};
        vecs[12] = '{4'd6, 4'd1, 64'd5, 64'd5, 64'd0};
        vecs[13] = '{4'd7, 4'd6, 64'd0, 64'd0, 64'd0};
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].code, vecs[i].fun, vecs[i].a, vecs[i].b, vecs[i].c, 1'b0);
        end
        check("final_cc_equal", {61'd0, cc}, 64'd4);

        step(4'd0, 4'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
